// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with registered sync, blank, strobe and frame outputs
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 10'd267,
  parameter int unsigned H_FP     = 10'd3,
  parameter int unsigned H_SYNC   = 10'd1,
  parameter int unsigned H_BP     = 10'd1,
  parameter int unsigned V_ACTIVE = 10'd240,
  parameter int unsigned V_FP     = 10'd2,
  parameter int unsigned V_SYNC   = 10'd1,
  parameter int unsigned V_BP     = 10'd3,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FC_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (((H_TOTAL >> CNT_W) != 0) || ((V_TOTAL >> CNT_W) != 0)) begin : g_size_check
    $error("video_timing_gen: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] HT_M1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VT_M1 = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HA    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSE   = CNT_W'((V_ACTIVE + V_FP + V_SYNC) % V_TOTAL);

  logic [CNT_W-1:0] r_x, r_y;
  logic             r_hs, r_vs, r_hb, r_vb, r_de, r_ls, r_fs;
  logic [FC_W-1:0]  r_fc;

  logic             w_x_wrap, w_y_wrap;
  logic [CNT_W-1:0] w_x_nxt, w_y_nxt;
  logic             w_hb_nxt, w_vb_nxt, w_hs_act, w_vs_act;

  assign w_x_wrap = (r_x == HT_M1);
  assign w_y_wrap = (r_y == VT_M1);
  assign w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
  assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? '0 : r_y + 1'b1) : r_y;
  assign w_hb_nxt = (w_x_nxt >= HA);
  assign w_vb_nxt = (w_y_nxt >= VA);
  assign w_hs_act = (w_x_nxt >= HSS) && (w_x_nxt < HSE);

  // vsync toggles only on the hsync leading-edge column so both edges line up with hsync
  always_comb begin
    w_vs_act = (r_vs == VS_POL);
    if (V_SYNC == 0) begin
      w_vs_act = 1'b0;
    end else if (w_x_nxt == HSS) begin
      if (w_y_nxt == VSS) begin
        w_vs_act = 1'b1;
      end else if (w_y_nxt == VSE) begin
        w_vs_act = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x  <= HT_M1;
      r_y  <= VT_M1;
      r_hb <= 1'b1;
      r_vb <= 1'b1;
      r_de <= 1'b0;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      r_fc <= '1;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      if (enable) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_hb <= w_hb_nxt;
        r_vb <= w_vb_nxt;
        r_de <= !w_hb_nxt && !w_vb_nxt;
        r_hs <= w_hs_act ? HS_POL : ~HS_POL;
        r_vs <= w_vs_act ? VS_POL : ~VS_POL;
        r_ls <= w_x_wrap;
        r_fs <= w_x_wrap && w_y_wrap;
        if (w_x_wrap && w_y_wrap) begin
          r_fc <= r_fc + 1'b1;
        end
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign hblank      = r_hb;
  assign vblank      = r_vb;
  assign de          = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_count = r_fc;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on an 8x6 raster
module tb_video_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
    logic       de;
    logic       ls;
    logic       fs;
    logic [1:0] fc;
  } out_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] x, y;
  logic       hsync, vsync, hblank, vblank, de, line_start, frame_start;
  logic [1:0] frame_count;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10), .FC_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .de(de),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_x = 7, m_y = 5, m_fc = 3;
  bit   m_ls = 0, m_fs = 0;

  int   ls_cnt = 0, vb_cnt = 0;
  int   rise_x = -1, rise_y = -1, fall_x = -1, fall_y = -1;
  int   fc_log[$];
  logic prev_vs = 1'b0;

  function automatic out_t lit(int lx, int ly, bit hs, bit vs, bit hb, bit vb,
                               bit lde, bit ls, bit fs, int fc);
    out_t o;
    o.x = 10'(lx); o.y = 10'(ly); o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb;
    o.de = lde; o.ls = ls; o.fs = fs; o.fc = 2'(fc);
    return o;
  endfunction

  // vsync window expressed as a linear pixel index range: (5,4) up to but excluding (5,5)
  function automatic out_t mdl();
    int  p;
    bit  hb, vb;
    p  = m_y * 8 + m_x;
    hb = (m_x >= 4);
    vb = (m_y >= 3);
    return lit(m_x, m_y, (m_x >= 5) && (m_x <= 6), (p >= 37) && (p < 45),
               hb, vb, !hb && !vb, m_ls, m_fs, m_fc);
  endfunction

  task automatic drive(input bit en, input bit rst, input bit use_lit, input out_t lv);
    @(negedge clk);
    enable  = en;
    reset_n = rst;
    if (!rst) begin
      m_x = 7; m_y = 5; m_fc = 3; m_ls = 0; m_fs = 0;
    end else if (en) begin
      if (m_x == 7) begin
        m_x = 0;
        m_y = (m_y == 5) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
      m_ls = (m_x == 0);
      m_fs = m_ls && (m_y == 0);
      if (m_fs) m_fc = (m_fc + 1) % 4;
    end else begin
      m_ls = 0; m_fs = 0;
    end
    exp_q.push_back(use_lit ? lv : mdl());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic sync_mon();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  initial begin : monitor
    out_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {x, y, hsync, vsync, hblank, vblank, de, line_start, frame_start, frame_count};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL vec%0d: got x=%0d y=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b fc=%0d",
                   n_vec, a.x, a.y, a.hs, a.vs, a.hb, a.vb, a.de, a.ls, a.fs, a.fc,
                   e.x, e.y, e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, e.fc);
        end
        if (line_start === 1'b1) ls_cnt++;
        if (vblank === 1'b1) vb_cnt++;
        if (vsync === 1'b1 && prev_vs === 1'b0) begin rise_x = int'(x); rise_y = int'(y); end
        if (vsync === 1'b0 && prev_vs === 1'b1) begin fall_x = int'(x); fall_y = int'(y); end
        if (frame_start === 1'b1) fc_log.push_back(int'(frame_count));
        prev_vs = vsync;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    out_t rst_v;
    logic [7:0] hb_t, hs_t, de_t;
    int exp_fc[5];
    rst_v = lit(7, 5, 0, 0, 1, 1, 0, 0, 0, 3);
    hb_t = 8'b1111_0000;
    hs_t = 8'b0110_0000;
    de_t = 8'b0000_1111;
    exp_fc = '{0, 1, 2, 3, 0};

    drive(1'b1, 1'b0, 1'b1, rst_v);
    drive(1'b1, 1'b0, 1'b1, rst_v);
    sync_mon();
    ls_cnt = 0; vb_cnt = 0;

    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 1'b1, lit(i, 0, hs_t[i], 0, hb_t[i], 0, de_t[i], i == 0, i == 0, 0));
    run(40);
    sync_mon();
    chk("line_starts_per_frame", ls_cnt, 6);
    chk("vblank_cycles_per_frame", vb_cnt, 24);
    chk("vsync_rise_x", rise_x, 5);
    chk("vsync_rise_y", rise_y, 4);
    chk("vsync_fall_x", fall_x, 5);
    chk("vsync_fall_y", fall_y, 5);

    drive(1'b1, 1'b1, 1'b1, lit(0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    drive(1'b0, 1'b1, 1'b1, lit(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    drive(1'b0, 1'b1, 1'b1, lit(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    drive(1'b1, 1'b1, 1'b1, lit(1, 0, 0, 0, 0, 0, 1, 0, 0, 1));

    run(18);
    drive(1'b1, 1'b0, 1'b1, rst_v);
    drive(1'b1, 1'b1, 1'b1, lit(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    drive(1'b1, 1'b1, 1'b1, lit(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    drive(1'b1, 1'b0, 1'b1, rst_v);
    sync_mon();
    fc_log.delete();
    run(193);
    sync_mon();
    chk("frame_start_count", fc_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("frame_count_seq%0d", i), (i < fc_log.size()) ? fc_log[i] : -1, exp_fc[i]);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) sync_mon();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
